tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Time-division demultiplexer: receives a slot-serialized stream (one W-bit sample per slot, NCH slots per frame) and rebuilds all NCH channel lanes in parallel.
- It is the receive end of the gate-level 2:1/N:1 mux path. Those muxes select one source onto a shared wire; this block separates the shared wire back into channels.
- It locks to the frame marker, checks framing, and presents each complete frame atomically with a one-cycle valid pulse.

Parameters:
- SW, 2, slot-index width; NCH = 2**SW slots per frame (localparam, not overridable).
- W, 1, data bits per slot.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- slot_en  in  1  slot strobe; din/fsync are sampled only when high.
- din  in  W  slot sample.
- fsync  in  1  high with slot_en on slot 0 of each frame.
- ch_out  out  NCH*W  frame lanes; slot k at ch_out[k*W +: W].
- frame_vld  out  1  one-cycle pulse; ch_out holds a new frame.
- locked  out  1  high while in LOCKED.
- sync_err  out  1  sticky framing-error flag.
- err_clr  in  1  synchronous clear of sync_err.

Behaviour:
- Reset (rst_n=0, async): state=HUNT, slot counter=0, shadow=0, ch_out=0, frame_vld=0, locked=0, sync_err=0. Reset mid-frame discards the partial frame.
- Registers only; no combinational path from inputs to outputs.
- States:
  - HUNT: cycles without slot_en, and slot_en with fsync=0, are ignored.
  - HUNT, slot_en&fsync: shadow[0]<=din, cnt<=1, go LOCKED.
  - LOCKED, slot_en, cnt!=0, fsync=0: shadow[cnt]<=din, cnt<=cnt+1 (wraps NCH-1 -> 0).
  - LOCKED, slot_en, cnt==0, fsync=1: normal frame start; shadow[0]<=din, cnt<=1.
  - LOCKED, slot_en, cnt==0, fsync=0: missing marker; sync_err<=1, go HUNT, din discarded.
  - LOCKED, slot_en, cnt!=0, fsync=1: early marker; sync_err<=1, partial frame discarded, stay LOCKED, treat the slot as slot 0 (shadow[0]<=din, cnt<=1).
- Frame completion: slot_en at cnt==NCH-1 with no error loads ch_out with shadow[0..NCH-2] plus that din. frame_vld=1 in the following cycle only, so latency is 1 clock after the last slot strobe.
- ch_out updates atomically and only on frame completion. It holds its value otherwise, including through HUNT and errors.
- locked is a registered copy of state==LOCKED.
- sync_err: set has priority over err_clr in the same cycle; stays cleared when no new error occurs.
- Back-to-back frames (slot_en every cycle) are supported with no gap cycles.
- W and SW are arbitrary ≥1; the counter wraps naturally at 2**SW.

Optional Feature:
- Macro TDM_DEMUX_PARITY_EN.
- Defined:
  - Each frame carries one extra trailing slot (index NCH) whose bit 0 is the even parity over all NCH*W data bits. The counter gains a terminal state for this slot.
  - Completion moves to the parity slot. Parity match: ch_out loads, frame_vld pulses. Mismatch: ch_out unchanged, no frame_vld, output port par_err (1 bit, reset 0) pulses for one cycle; lock is kept.
  - fsync on the parity slot is an early marker (rule above).
- Undefined: no parity slot, no par_err port, behaviour exactly as above.

Test Plan:
- Reset, then frame fsync/din = slot0..3: 1,0,1,1 with slot_en every cycle -> locked=1 after first strobe; one cycle after slot3, ch_out=4'b1101 and frame_vld=1 for exactly one cycle.
- Two back-to-back frames 1,1,0,0 then 0,1,0,1 -> frame_vld pulses exactly 4 cycles apart; ch_out=4'b0011 then 4'b1010.
- slot_en toggling 1,0,1,0 during frame 0,1,1,0 -> gaps ignored; ch_out=4'b0110 one cycle after the 4th strobe.
- After lock, fsync=1 at slot2 -> sync_err=1, no frame_vld, ch_out unchanged; next 3 strobes complete a frame using the early-marker slot as slot 0.
- Missing fsync at slot0 -> sync_err=1, locked=0, stream ignored until next fsync. err_clr=1 with no new error clears sync_err; err_clr and an error in the same cycle -> sync_err stays 1.
- Assert rst_n low after slot1 of a frame -> all outputs 0 immediately (asynchronous). With TDM_DEMUX_PARITY_EN: frame 1,0,1,1 with parity 1 -> frame_vld; with parity 0 -> par_err pulse and no frame_vld.

Source files
------------

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: locks to fsync and rebuilds NCH lanes of W bits from a slot-serial stream.
// Optional macro TDM_DEMUX_PARITY_EN adds a trailing even-parity slot per frame and a par_err pulse output.
module tdm_demux #(
  parameter  int SW  = 2,
  parameter  int W   = 1,
  localparam int NCH = 2**SW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slot_en,
  input  logic [W-1:0]     din,
  input  logic             fsync,
  input  logic             err_clr,
  output logic [NCH*W-1:0] ch_out,
  output logic             frame_vld,
  output logic             locked,
  output logic             sync_err
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic             par_err
`endif
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int CW = SW + 1;
`else
  localparam int CW = SW;
`endif
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  function automatic logic even_par(input logic [NCH*W-1:0] d);
    return ^d;
  endfunction

  state_t            state_r, state_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [NCH*W-1:0]  shadow_r, shadow_s;
  logic [NCH*W-1:0]  ch_out_r, ch_s;
  logic              frame_vld_r, vld_s;
  logic              locked_r;
  logic              sync_err_r, err_s, err_set_s;
`ifdef TDM_DEMUX_PARITY_EN
  logic              par_err_r, par_s;
`endif

  // Framing state machine: slot capture, error detection and frame completion.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    shadow_s  = shadow_r;
    ch_s      = ch_out_r;
    vld_s     = 1'b0;
    err_set_s = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    par_s     = 1'b0;
`endif
    if (slot_en) begin
      if (state_r == HUNT) begin
        if (fsync) begin
          shadow_s[W-1:0] = din;
          cnt_s           = CW'(1);
          state_s         = LOCKED;
        end else begin
          state_s = HUNT;
        end
      end else if (fsync) begin
        // A marker anywhere but slot 0 restarts the frame on this slot.
        err_set_s       = (cnt_r != CW'(0));
        shadow_s[W-1:0] = din;
        cnt_s           = CW'(1);
      end else if (cnt_r == CW'(0)) begin
        err_set_s = 1'b1;
        state_s   = HUNT;
`ifdef TDM_DEMUX_PARITY_EN
      end else if (cnt_r == CW'(NCH)) begin
        if (even_par(shadow_r) == din[0]) begin
          ch_s  = shadow_r;
          vld_s = 1'b1;
        end else begin
          par_s = 1'b1;
        end
        cnt_s = CW'(0);
`endif
      end else begin
        for (int k = 0; k < NCH; k++) begin
          shadow_s[k*W +: W] = (cnt_r == CW'(k)) ? din : shadow_r[k*W +: W];
        end
        cnt_s = cnt_r + CW'(1);
`ifndef TDM_DEMUX_PARITY_EN
        if (cnt_r == LAST) begin
          ch_s  = shadow_s;
          vld_s = 1'b1;
        end else begin
          vld_s = 1'b0;
        end
`endif
      end
    end else begin
      state_s = state_r;
    end

    if (err_set_s) begin
      err_s = 1'b1;
    end else if (err_clr) begin
      err_s = 1'b0;
    end else begin
      err_s = sync_err_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= HUNT;
      cnt_r       <= CW'(0);
      shadow_r    <= '0;
      ch_out_r    <= '0;
      frame_vld_r <= 1'b0;
      locked_r    <= 1'b0;
      sync_err_r  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_err_r   <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      shadow_r    <= shadow_s;
      ch_out_r    <= ch_s;
      frame_vld_r <= vld_s;
      locked_r    <= (state_s == LOCKED);
      sync_err_r  <= err_s;
`ifdef TDM_DEMUX_PARITY_EN
      par_err_r   <= par_s;
`endif
    end
  end

  assign ch_out    = ch_out_r;
  assign frame_vld = frame_vld_r;
  assign locked    = locked_r;
  assign sync_err  = sync_err_r;
`ifdef TDM_DEMUX_PARITY_EN
  assign par_err   = par_err_r;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed framing cases plus random slot streams against a queue-based frame model.
module tb_tdm_demux;
  localparam int SW  = 2;
  localparam int W   = 1;
  localparam int NCH = 2**SW;
  localparam int DW  = NCH*W;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FL  = NCH + 1;
`else
  localparam int FL  = NCH;
`endif

  logic          clk = 1'b0;
  logic          rst_n, slot_en, fsync, err_clr;
  logic [W-1:0]  din;
  logic [DW-1:0] ch_out;
  logic          frame_vld, locked, sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic          par_err;
`endif

  tdm_demux #(.SW(SW), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .slot_en(slot_en), .din(din), .fsync(fsync),
    .err_clr(err_clr), .ch_out(ch_out), .frame_vld(frame_vld),
    .locked(locked), .sync_err(sync_err)
`ifdef TDM_DEMUX_PARITY_EN
    , .par_err(par_err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_vld_cyc = 0;
  int prev_vld_cyc = 0;

  // Reference model: a frame is a queue of received samples since the last marker.
  logic [W-1:0]  m_q[$];
  bit            m_locked = 1'b0;
  logic [DW-1:0] m_ch = '0;
  bit            m_vld = 1'b0;
  bit            m_err = 1'b0;
  bit            m_perr = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_locked = 1'b0;
    m_ch = '0;
    m_vld = 1'b0;
    m_err = 1'b0;
    m_perr = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic fs, input logic [W-1:0] d, input logic clr);
    bit set;
    logic [DW-1:0] data;
    set = 1'b0;
    m_vld = 1'b0;
    m_perr = 1'b0;
    if (en) begin
      if (!m_locked) begin
        if (fs) begin
          m_q = {d};
          m_locked = 1'b1;
        end
      end else if (fs) begin
        if (m_q.size() != 0) set = 1'b1;
        m_q = {d};
      end else if (m_q.size() == 0) begin
        set = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == FL) begin
          for (int k = 0; k < NCH; k++) data[k*W +: W] = m_q[k];
`ifdef TDM_DEMUX_PARITY_EN
          if ((^data) == m_q[NCH][0]) begin
            m_ch = data;
            m_vld = 1'b1;
          end else begin
            m_perr = 1'b1;
          end
`else
          m_ch = data;
          m_vld = 1'b1;
`endif
          m_q.delete();
        end
      end
    end
    if (set) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  task automatic compare_all();
    check("ch_out", 64'(ch_out), 64'(m_ch));
    check("frame_vld", 64'(frame_vld), 64'(m_vld));
    check("locked", 64'(locked), 64'(m_locked));
    check("sync_err", 64'(sync_err), 64'(m_err));
`ifdef TDM_DEMUX_PARITY_EN
    check("par_err", 64'(par_err), 64'(m_perr));
`endif
  endtask

  task automatic step(input logic en, input logic fs, input logic [W-1:0] d, input logic clr);
    slot_en = en;
    fsync   = fs;
    din     = d;
    err_clr = clr;
    @(posedge clk);
    model_edge(en, fs, d, clr);
    #1;
    cyc++;
    if (frame_vld) begin
      prev_vld_cyc = last_vld_cyc;
      last_vld_cyc = cyc;
    end
    compare_all();
  endtask

  // Sends slots first..NCH-1 of frame f (marker on slot 0), plus the parity slot when enabled.
  task automatic send_frame(input logic [DW-1:0] f, input int first, input bit gaps);
    logic [W-1:0] p;
    for (int k = first; k < NCH; k++) begin
      step(1'b1, (k == 0), f[k*W +: W], 1'b0);
      if (gaps && (k < NCH-1)) step(1'b0, 1'b0, W'(0), 1'b0);
    end
`ifdef TDM_DEMUX_PARITY_EN
    p = W'(^f);
    step(1'b1, 1'b0, p, 1'b0);
`else
    p = W'(0);
`endif
  endtask

  initial begin
    logic en, fs, clr;
    rst_n = 1'b0; slot_en = 1'b0; fsync = 1'b0; din = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // First frame 1,0,1,1 -> lanes 1101
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("tp1_locked", 64'(locked), 64'd1);
    send_frame(4'b1101, 1, 1'b0);
    check("tp1_ch", 64'(ch_out), 64'(4'b1101));
    check("tp1_vld", 64'(frame_vld), 64'd1);

    // Back-to-back frames
    send_frame(4'b0011, 0, 1'b0);
    check("tp2_ch_a", 64'(ch_out), 64'(4'b0011));
    send_frame(4'b1010, 0, 1'b0);
    check("tp2_ch_b", 64'(ch_out), 64'(4'b1010));
    check("tp2_gap", 64'(last_vld_cyc - prev_vld_cyc), 64'(FL));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("tp2_vld_off", 64'(frame_vld), 64'd0);

    // Strobe gaps
    send_frame(4'b0110, 0, 1'b1);
    check("tp3_ch", 64'(ch_out), 64'(4'b0110));

    // Early marker at slot 2
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("early_err", 64'(sync_err), 64'd1);
    check("early_vld", 64'(frame_vld), 64'd0);
    check("early_hold", 64'(ch_out), 64'(4'b0110));
    send_frame(4'b0111, 1, 1'b0);
    check("early_ch", 64'(ch_out), 64'(4'b0111));

    // Missing marker, then err_clr behaviour
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("miss_err", 64'(sync_err), 64'd1);
    check("miss_lock", 64'(locked), 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_err", 64'(sync_err), 64'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("set_over_clr", 64'(sync_err), 64'd1);

    // Asynchronous reset mid-frame
    step(1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("arst_ch", 64'(ch_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("par_ok_vld", 64'(frame_vld), 64'd1);
    check("par_ok_ch", 64'(ch_out), 64'(4'b1101));
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("par_bad_perr", 64'(par_err), 64'd1);
    check("par_bad_vld", 64'(frame_vld), 64'd0);
    check("par_bad_lock", 64'(locked), 64'd1);
`endif

    // Random stream, mostly well-framed with occasional errors and gaps
    for (int i = 0; i < 1500; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      fs  = (m_q.size() == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 19) == 0);
      clr = ($urandom_range(0, 7) == 0);
      step(en, fs, W'($urandom), clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
